// File: rtl/ecc_scrubber.sv
// Background scrubber for a RAM of 39-bit SECDED codewords (32 data + 7 check bits).
// Walks every address, decodes each word, writes back single-bit corrections and
// counts/logs single and double errors. The user port always wins arbitration.
//
// Codeword layout: Hamming positions 1..38 carry check bits at powers of two and
// data bits elsewhere (ascending), bit 0 holds overall even parity.
module ecc_scrubber #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned INTERVAL = 1024,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic              clr_i,
  input  logic              user_req_i,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [38:0]       ram_wdata_o,
  input  logic [38:0]       ram_rdata_i,
  output logic              busy_o,
  output logic              pass_done_o,
  output logic [CNT_W-1:0]  sec_cnt_o,
  output logic [CNT_W-1:0]  ded_cnt_o,
  output logic              ded_flag_o,
  output logic [ADDR_W-1:0] ded_addr_o
);

  localparam int unsigned IntW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam int unsigned LatW = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
  localparam logic [IntW-1:0] IntLast = IntW'(INTERVAL - 1);
  localparam logic [LatW-1:0] LatLast = (RD_LAT > 1) ? LatW'(RD_LAT - 2) : '0;

  typedef enum logic [2:0] {
    StIdle, StWaitInt, StRead, StWaitRd, StCheck, StWrite, StNext
  } state_e;

  // Build a codeword: data in non-power-of-two positions, check bits at 2**k,
  // overall parity in bit 0.
  function automatic logic [38:0] ecc_encode(input logic [31:0] data);
    logic [38:0] cw;
    logic        p;
    int unsigned j;
    cw = '0;
    j  = 0;
    for (int i = 1; i < 39; i++) begin
      if ((i & (i - 1)) != 0) begin
        cw[i] = data[j];
        j++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      p = 1'b0;
      for (int i = 3; i < 39; i++) begin
        if ((((i >> k) & 1) != 0) && ((i & (i - 1)) != 0)) p ^= cw[i];
      end
      cw[1 << k] = p;
    end
    cw[0] = ^cw[38:1];
    return cw;
  endfunction

  // Pull the 32 data bits back out of a codeword.
  function automatic logic [31:0] ecc_extract(input logic [38:0] cw);
    logic [31:0] data;
    int unsigned j;
    data = '0;
    j    = 0;
    for (int i = 1; i < 39; i++) begin
      if ((i & (i - 1)) != 0) begin
        data[j] = cw[i];
        j++;
      end
    end
    return data;
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [IntW-1:0]     int_cnt_q, int_cnt_d;
  logic [LatW-1:0]     lat_cnt_q, lat_cnt_d;
  logic                hazard_q, hazard_d;
  logic [38:0]         wdata_q, wdata_d;
  logic                pass_done_q, pass_done_d;
  logic [CNT_W-1:0]    sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0]    ded_cnt_q, ded_cnt_d;
  logic                ded_flag_q, ded_flag_d;
  logic [ADDR_W-1:0]   ded_addr_q, ded_addr_d;

  logic [5:0]          syn;
  logic                par;
  logic                dec_single;
  logic                dec_double;
  logic [38:0]         fixed_cw;

  // Decoder: syndrome is the XOR of the positions of all set bits.
  always_comb begin
    syn = '0;
    for (int i = 1; i < 39; i++) begin
      if (ram_rdata_i[i]) syn ^= 6'(i);
    end
    par        = ^ram_rdata_i;
    dec_single = par && (syn < 6'd39);
    dec_double = (!par && (syn != '0)) || (par && (syn >= 6'd39));
    fixed_cw   = ram_rdata_i;
    // syn == 0 with bad parity means bit 0 itself flipped
    if (dec_single) fixed_cw[syn] = ~fixed_cw[syn];
  end

  // Next-state logic for the scrub FSM, counters and error log.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    int_cnt_d   = int_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    hazard_d    = hazard_q;
    wdata_d     = wdata_q;
    pass_done_d = 1'b0;
    sec_cnt_d   = sec_cnt_q;
    ded_cnt_d   = ded_cnt_q;
    ded_flag_d  = ded_flag_q;
    ded_addr_d  = ded_addr_q;

    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d   = StWaitInt;
          int_cnt_d = '0;
        end
      end
      StWaitInt: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (int_cnt_q == IntLast) begin
          state_d   = StRead;
          int_cnt_d = '0;
        end else begin
          int_cnt_d = int_cnt_q + 1'b1;
        end
      end
      StRead: begin
        if (!user_req_i) begin
          hazard_d  = 1'b0;
          lat_cnt_d = '0;
          state_d   = (RD_LAT == 1) ? StCheck : StWaitRd;
        end
      end
      StWaitRd: begin
        hazard_d = hazard_q | user_req_i;
        if (lat_cnt_q == LatLast) state_d = StCheck;
        else                      lat_cnt_d = lat_cnt_q + 1'b1;
      end
      StCheck: begin
        hazard_d = hazard_q | user_req_i;
        if (dec_single) begin
          if (sec_cnt_q != '1) sec_cnt_d = sec_cnt_q + 1'b1;
          wdata_d = ecc_encode(ecc_extract(fixed_cw));
          state_d = StWrite;
        end else if (dec_double) begin
          if (ded_cnt_q != '1) ded_cnt_d = ded_cnt_q + 1'b1;
          ded_flag_d = 1'b1;
          if (!ded_flag_q) ded_addr_d = addr_q;
          state_d = StNext;
        end else begin
          state_d = StNext;
        end
      end
      StWrite: begin
        // The user may have rewritten the word since our read: re-read it.
        if (user_req_i)    hazard_d = 1'b1;
        else if (hazard_q) state_d  = StRead;
        else               state_d  = StNext;
      end
      StNext: begin
        addr_d    = addr_q + 1'b1;
        int_cnt_d = '0;
        if (addr_q == '1) pass_done_d = 1'b1;
        state_d = enable_i ? StWaitInt : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (clr_i) begin
      sec_cnt_d  = '0;
      ded_cnt_d  = '0;
      ded_flag_d = 1'b0;
      ded_addr_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      int_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      hazard_q    <= 1'b0;
      wdata_q     <= '0;
      pass_done_q <= 1'b0;
      sec_cnt_q   <= '0;
      ded_cnt_q   <= '0;
      ded_flag_q  <= 1'b0;
      ded_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      int_cnt_q   <= int_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      hazard_q    <= hazard_d;
      wdata_q     <= wdata_d;
      pass_done_q <= pass_done_d;
      sec_cnt_q   <= sec_cnt_d;
      ded_cnt_q   <= ded_cnt_d;
      ded_flag_q  <= ded_flag_d;
      ded_addr_q  <= ded_addr_d;
    end
  end

  // Strobes are gated by user_req_i in the same cycle so the user always wins.
  assign ram_we_o    = (state_q == StWrite) && !hazard_q && !user_req_i;
  assign ram_en_o    = ((state_q == StRead) && !user_req_i) || ram_we_o;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign busy_o      = (state_q != StIdle);
  assign pass_done_o = pass_done_q;
  assign sec_cnt_o   = sec_cnt_q;
  assign ded_cnt_o   = ded_cnt_q;
  assign ded_flag_o  = ded_flag_q;
  assign ded_addr_o  = ded_addr_q;

endmodule

// File: tb/tb_ecc_scrubber.sv
// Directed bench for ecc_scrubber with a small RAM model (RD_LAT=2, 4 words).
module tb_ecc_scrubber;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned RD_LAT   = 2;
  localparam int unsigned INTERVAL = 4;
  localparam int unsigned CNT_W    = 4;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              enable_i = 1'b0;
  logic              clr_i = 1'b0;
  logic              user_req_i = 1'b0;
  logic              ram_en_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [38:0]       ram_wdata_o;
  logic [38:0]       ram_rdata_i;
  logic              busy_o;
  logic              pass_done_o;
  logic [CNT_W-1:0]  sec_cnt_o;
  logic [CNT_W-1:0]  ded_cnt_o;
  logic              ded_flag_o;
  logic [ADDR_W-1:0] ded_addr_o;

  ecc_scrubber #(
    .ADDR_W  (ADDR_W),
    .RD_LAT  (RD_LAT),
    .INTERVAL(INTERVAL),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .enable_i   (enable_i),
    .clr_i      (clr_i),
    .user_req_i (user_req_i),
    .ram_en_o   (ram_en_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i),
    .busy_o     (busy_o),
    .pass_done_o(pass_done_o),
    .sec_cnt_o  (sec_cnt_o),
    .ded_cnt_o  (ded_cnt_o),
    .ded_flag_o (ded_flag_o),
    .ded_addr_o (ded_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [38:0]       wdata;
    int                cyc;
  } acc_t;

  acc_t        acc_q[$];
  logic [38:0] mem [4];
  logic [31:0] dat [4];
  logic [38:0] rd_p0 = '1;
  logic [38:0] rd_p1 = '1;
  bit          drop_wr = 1'b0;
  int          cyc = 0;
  int          pass_cnt = 0;
  int          viol = 0;
  int          vecs = 0;
  int          errs = 0;

  assign ram_rdata_i = rd_p1;

  // RAM model with two-cycle read latency plus an access log.
  always @(posedge clk_i) begin
    acc_t a;
    if (ram_en_o) begin
      a.we    = ram_we_o;
      a.addr  = ram_addr_o;
      a.wdata = ram_wdata_o;
      a.cyc   = cyc;
      acc_q.push_back(a);
    end
    if (ram_en_o && user_req_i) viol++;
    if (ram_we_o && !ram_en_o) viol++;
    if (pass_done_o) pass_cnt++;
    rd_p1 <= rd_p0;
    rd_p0 <= (ram_en_o && !ram_we_o) ? mem[ram_addr_o] : '1;
    if (ram_en_o && ram_we_o && !drop_wr) mem[ram_addr_o] = ram_wdata_o;
    cyc++;
  end

  // Reference encoder: check bits are the XOR of the positions of set data bits.
  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [38:0] cw;
    logic [5:0]  s;
    int          j;
    cw = '0;
    s  = '0;
    j  = 0;
    for (int p = 1; p < 39; p++) begin
      if (p == 1 || p == 2 || p == 4 || p == 8 || p == 16 || p == 32) continue;
      cw[p] = d[j];
      if (d[j]) s ^= 6'(p);
      j++;
    end
    for (int k = 0; k < 6; k++) cw[1 << k] = s[k];
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic logic [38:0] flip(input logic [38:0] cw, input int b);
    return cw ^ (39'd1 << b);
  endfunction

  function automatic int n_reads();
    int n;
    n = 0;
    foreach (acc_q[i]) if (!acc_q[i].we) n++;
    return n;
  endfunction

  function automatic int n_writes();
    int n;
    n = 0;
    foreach (acc_q[i]) if (acc_q[i].we) n++;
    return n;
  endfunction

  task automatic do_reset();
    rst_n_i = 1'b0; enable_i = 1'b0; clr_i = 1'b0; user_req_i = 1'b0; drop_wr = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    for (int i = 0; i < 4; i++) mem[i] = enc(dat[i]);
    acc_q.delete();
    pass_cnt = 0;
    viol     = 0;
    rst_n_i  = 1'b1;
  endtask

  task automatic wait_reads(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (n_reads() < n && k < budget) begin
      @(posedge clk_i); #1; k++;
    end
    if (n_reads() < n) begin
      vecs++; errs++;
      $display("FAIL %s timeout: reads=%0d need=%0d", tag, n_reads(), n);
    end
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (n_writes() < n && k < budget) begin
      @(posedge clk_i); #1; k++;
    end
    if (n_writes() < n) begin
      vecs++; errs++;
      $display("FAIL %s timeout: writes=%0d need=%0d", tag, n_writes(), n);
    end
  endtask

  task automatic wait_pass(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (pass_cnt < n && k < budget) begin
      @(posedge clk_i); #1; k++;
    end
    if (pass_cnt < n) begin
      vecs++; errs++;
      $display("FAIL %s timeout: passes=%0d need=%0d", tag, pass_cnt, n);
    end
  endtask

  // Returns in the cycle after a read strobe to address a.
  task automatic wait_read_addr(input int a, input int budget, input string tag);
    int k;
    int n0;
    bit hit;
    k   = 0;
    hit = 1'b0;
    n0  = acc_q.size();
    while (!hit && k < budget) begin
      @(posedge clk_i); #1; k++;
      if (acc_q.size() > n0) begin
        if (!acc_q[$].we && acc_q[$].addr == ADDR_W'(a)) hit = 1'b1;
        n0 = acc_q.size();
      end
    end
    if (!hit) begin
      vecs++; errs++;
      $display("FAIL %s timeout: no read of addr %0d", tag, a);
    end
  endtask

  task automatic test_reset();
    logic [95:0] outs;
    rst_n_i = 1'b0; enable_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    outs = {ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, busy_o, pass_done_o,
            sec_cnt_o, ded_cnt_o, ded_flag_o, ded_addr_o};
    vecs++;
    if (outs !== '0) begin
      errs++; $display("FAIL reset_outputs: got %0h expected 0", outs);
    end
    do_reset();
    repeat (10) @(posedge clk_i);
    #1;
    vecs++;
    if (busy_o !== 1'b0) begin
      errs++; $display("FAIL idle_busy: got %0b expected 0", busy_o);
    end
    vecs++;
    if (acc_q.size() != 0) begin
      errs++; $display("FAIL idle_access: got %0d strobes expected 0", acc_q.size());
    end
  endtask

  task automatic test_clean_pass();
    do_reset();
    enable_i = 1'b1;
    wait_pass(1, 200, "clean_pass");
    enable_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;
    vecs++;
    if (acc_q.size() != 4) begin
      errs++; $display("FAIL clean_strobes: got %0d expected 4", acc_q.size());
    end
    for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
      vecs++;
      if (acc_q[i].we !== 1'b0 || acc_q[i].addr !== ADDR_W'(i)) begin
        errs++;
        $display("FAIL clean_read%0d: got we=%0b addr=%0d expected we=0 addr=%0d",
                 i, acc_q[i].we, acc_q[i].addr, i);
      end
      if (i > 0) begin
        vecs++;
        if (acc_q[i].cyc - acc_q[i-1].cyc != 8) begin
          errs++;
          $display("FAIL clean_spacing%0d: got %0d expected 8", i,
                   acc_q[i].cyc - acc_q[i-1].cyc);
        end
      end
    end
    vecs++;
    if (pass_cnt != 1) begin
      errs++; $display("FAIL clean_pass_done: got %0d pulse cycles expected 1", pass_cnt);
    end
    vecs++;
    if (sec_cnt_o !== '0 || ded_cnt_o !== '0) begin
      errs++; $display("FAIL clean_counts: got sec=%0d ded=%0d expected 0/0", sec_cnt_o, ded_cnt_o);
    end
    vecs++;
    if (busy_o !== 1'b0) begin
      errs++; $display("FAIL clean_idle: got busy=%0b expected 0", busy_o);
    end
  endtask

  task automatic test_single_error();
    do_reset();
    mem[2] = flip(enc(dat[2]), 5);
    enable_i = 1'b1;
    wait_pass(2, 300, "sec_pass");
    enable_i = 1'b0;
    repeat (12) @(posedge clk_i);
    #1;
    vecs++;
    if (n_writes() != 1) begin
      errs++; $display("FAIL sec_writes: got %0d expected 1", n_writes());
    end
    foreach (acc_q[i]) begin
      if (acc_q[i].we) begin
        vecs++;
        if (acc_q[i].addr !== 2'd2 || acc_q[i].wdata !== enc(dat[2])) begin
          errs++;
          $display("FAIL sec_wdata: got addr=%0d data=%0h expected addr=2 data=%0h",
                   acc_q[i].addr, acc_q[i].wdata, enc(dat[2]));
        end
      end
    end
    vecs++;
    if (sec_cnt_o !== 4'd1) begin
      errs++; $display("FAIL sec_count: got %0d expected 1", sec_cnt_o);
    end
    vecs++;
    if (ded_cnt_o !== '0 || ded_flag_o !== 1'b0) begin
      errs++; $display("FAIL sec_no_ded: got cnt=%0d flag=%0b expected 0/0", ded_cnt_o, ded_flag_o);
    end
  endtask

  task automatic test_double_error();
    do_reset();
    mem[1] = flip(flip(enc(dat[1]), 3), 17);
    mem[3] = flip(flip(enc(dat[3]), 0), 9);
    enable_i = 1'b1;
    wait_reads(3, 100, "ded_first");
    vecs++;
    if (ded_cnt_o !== 4'd1 || ded_flag_o !== 1'b1 || ded_addr_o !== 2'd1) begin
      errs++;
      $display("FAIL ded_first: got cnt=%0d flag=%0b addr=%0d expected 1/1/1",
               ded_cnt_o, ded_flag_o, ded_addr_o);
    end
    wait_pass(1, 100, "ded_pass");
    enable_i = 1'b0;
    repeat (12) @(posedge clk_i);
    #1;
    vecs++;
    if (ded_cnt_o !== 4'd2 || ded_flag_o !== 1'b1 || ded_addr_o !== 2'd1) begin
      errs++;
      $display("FAIL ded_second: got cnt=%0d flag=%0b addr=%0d expected 2/1/1",
               ded_cnt_o, ded_flag_o, ded_addr_o);
    end
    vecs++;
    if (n_writes() != 0 || sec_cnt_o !== '0) begin
      errs++; $display("FAIL ded_nowrite: got writes=%0d sec=%0d expected 0/0", n_writes(), sec_cnt_o);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    mem[0] = flip(enc(dat[0]), 7);
    enable_i = 1'b1;
    wait_reads(1, 40, "haz_read");
    user_req_i = 1'b1;
    @(posedge clk_i); #1;
    user_req_i = 1'b0;
    wait_writes(1, 60, "haz_write");
    enable_i = 1'b0;
    repeat (12) @(posedge clk_i);
    #1;
    vecs++;
    if (acc_q.size() != 3) begin
      errs++; $display("FAIL haz_strobes: got %0d expected 3", acc_q.size());
    end
    if (acc_q.size() >= 3) begin
      vecs++;
      if (acc_q[1].we !== 1'b0 || acc_q[1].addr !== 2'd0 || acc_q[1].cyc - acc_q[0].cyc != 4) begin
        errs++;
        $display("FAIL haz_reread: got we=%0b addr=%0d gap=%0d expected 0/0/4",
                 acc_q[1].we, acc_q[1].addr, acc_q[1].cyc - acc_q[0].cyc);
      end
      vecs++;
      if (acc_q[2].we !== 1'b1 || acc_q[2].addr !== 2'd0 || acc_q[2].wdata !== enc(dat[0])) begin
        errs++;
        $display("FAIL haz_writeback: got we=%0b addr=%0d data=%0h expected 1/0/%0h",
                 acc_q[2].we, acc_q[2].addr, acc_q[2].wdata, enc(dat[0]));
      end
    end
    vecs++;
    if (sec_cnt_o !== 4'd2) begin
      errs++; $display("FAIL haz_sec_count: got %0d expected 2", sec_cnt_o);
    end
    vecs++;
    if (viol != 0) begin
      errs++; $display("FAIL haz_port_rule: got %0d violations expected 0", viol);
    end
    vecs++;
    if (mem[0] !== enc(dat[0])) begin
      errs++; $display("FAIL haz_mem: got %0h expected %0h", mem[0], enc(dat[0]));
    end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    drop_wr = 1'b1;
    mem[0] = flip(enc(dat[0]), 5);
    mem[1] = flip(enc(dat[1]), 12);
    mem[2] = flip(enc(dat[2]), 30);
    mem[3] = flip(flip(enc(dat[3]), 2), 6);
    enable_i = 1'b1;
    wait_pass(6, 600, "sat_pass");
    vecs++;
    if (sec_cnt_o !== 4'hF) begin
      errs++; $display("FAIL sat_sec: got %0h expected f", sec_cnt_o);
    end
    vecs++;
    if (ded_cnt_o !== 4'd6 || ded_addr_o !== 2'd3 || ded_flag_o !== 1'b1) begin
      errs++;
      $display("FAIL sat_ded: got cnt=%0d addr=%0d flag=%0b expected 6/3/1",
               ded_cnt_o, ded_addr_o, ded_flag_o);
    end
    // Clear coincident with a double-error CHECK.
    wait_read_addr(3, 80, "clr_ded_read");
    @(posedge clk_i); #1;
    clr_i = 1'b1;
    @(posedge clk_i); #1;
    clr_i = 1'b0;
    vecs++;
    if (sec_cnt_o !== '0 || ded_cnt_o !== '0 || ded_flag_o !== 1'b0 || ded_addr_o !== '0) begin
      errs++;
      $display("FAIL clr_ded: got sec=%0d ded=%0d flag=%0b addr=%0d expected all 0",
               sec_cnt_o, ded_cnt_o, ded_flag_o, ded_addr_o);
    end
    // Clear coincident with a single-error CHECK.
    wait_read_addr(0, 80, "clr_sec_read");
    @(posedge clk_i); #1;
    clr_i = 1'b1;
    @(posedge clk_i); #1;
    clr_i = 1'b0;
    vecs++;
    if (sec_cnt_o !== '0 || ded_cnt_o !== '0) begin
      errs++; $display("FAIL clr_sec: got sec=%0d ded=%0d expected 0/0", sec_cnt_o, ded_cnt_o);
    end
    enable_i = 1'b0;
    drop_wr  = 1'b0;
    repeat (15) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset_mid_write();
    logic [95:0] outs;
    do_reset();
    mem[2] = flip(enc(dat[2]), 5);
    enable_i = 1'b1;
    wait_read_addr(2, 80, "rst_read");
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    vecs++;
    if (ram_we_o !== 1'b1 || sec_cnt_o !== 4'd1) begin
      errs++; $display("FAIL rst_in_write: got we=%0b sec=%0d expected 1/1", ram_we_o, sec_cnt_o);
    end
    rst_n_i = 1'b0;
    #1;
    outs = {ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, busy_o, pass_done_o,
            sec_cnt_o, ded_cnt_o, ded_flag_o, ded_addr_o};
    vecs++;
    if (outs !== '0) begin
      errs++; $display("FAIL rst_async_outputs: got %0h expected 0", outs);
    end
    repeat (3) @(posedge clk_i);
    #1;
    vecs++;
    if (n_writes() != 0 || mem[2] !== flip(enc(dat[2]), 5)) begin
      errs++; $display("FAIL rst_dropped_write: got writes=%0d mem=%0h", n_writes(), mem[2]);
    end
    acc_q.delete();
    rst_n_i = 1'b1;
    wait_reads(1, 40, "rst_restart");
    vecs++;
    if (acc_q.size() < 1 || acc_q[0].addr !== 2'd0) begin
      errs++; $display("FAIL rst_restart_addr: got %0d expected 0",
                       (acc_q.size() > 0) ? int'(acc_q[0].addr) : -1);
    end
    wait_writes(1, 80, "rst_rescrub");
    enable_i = 1'b0;
    repeat (12) @(posedge clk_i);
    #1;
    vecs++;
    if (mem[2] !== enc(dat[2])) begin
      errs++; $display("FAIL rst_rescrub: got %0h expected %0h", mem[2], enc(dat[2]));
    end
  endtask

  initial begin
    dat[0] = 32'hDEADBEEF;
    dat[1] = 32'h12345678;
    dat[2] = 32'hA5A50F0F;
    dat[3] = 32'h00000001;
    for (int i = 0; i < 4; i++) mem[i] = enc(dat[i]);
    test_reset();
    test_clean_pass();
    test_single_error();
    test_double_error();
    test_hazard();
    test_saturation_clear();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
